// File: rtl/fetch_stage_if.sv
// fetch_stage_if: bundles the fetch stage's datapath and control signals.
//
// Signal summary (directions as seen from the fetch stage, modport master):
//   stall_i        in   hold PC and IF/ID register
//   redirect_i     in   load redirect_pc_i and flush IF/ID
//   redirect_pc_i  in   redirect target (word index)
//   im_read_i      in   instruction word from instruction memory (combinational)
//   im_pc_o        out  PC presented to instruction memory
//   id_valid_o     out  IF/ID register holds a valid instruction
//   id_instr_o     out  registered instruction word
//   id_pc_o        out  PC of id_instr_o
//   id_pc_plus1_o  out  id_pc_o + PC_STEP
//   halted_o       out  fetch halted on SYSCALL
//   state_dbg      out  fetch FSM state (0 BOOT, 1 RUN, 2 HALT)
//
// Handshake: id_valid_o qualifies id_instr_o/id_pc_o/id_pc_plus1_o; the
// consumer applies back-pressure with stall_i, which freezes the PC and
// every id_* output. There is no separate ready; a word is consumed by
// downstream on every edge where id_valid_o=1 and stall_i=0.
interface fetch_stage_if;
    logic        stall_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic [31:0] im_read_i;
    logic [31:0] im_pc_o;
    logic        id_valid_o;
    logic [31:0] id_instr_o;
    logic [31:0] id_pc_o;
    logic [31:0] id_pc_plus1_o;
    logic        halted_o;
    logic [1:0]  state_dbg;

    modport master (
        input  stall_i, redirect_i, redirect_pc_i, im_read_i,
        output im_pc_o, id_valid_o, id_instr_o, id_pc_o, id_pc_plus1_o,
               halted_o, state_dbg
    );

    modport slave (
        output stall_i, redirect_i, redirect_pc_i, im_read_i,
        input  im_pc_o, id_valid_o, id_instr_o, id_pc_o, id_pc_plus1_o,
               halted_o, state_dbg
    );
endinterface

// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage. Owns the program counter, drives it
// to the instruction memory, and registers the returned word into the IF/ID
// pipeline register. Supports stall, redirect (flush) and halt on SYSCALL.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  synchronous active-low reset
//   bus    fetch_stage_if.master (see interface header for signal list)
module fetch_stage #(
    parameter logic [31:0] RESET_PC        = 32'h0000_0000,
    parameter logic [31:0] PC_STEP         = 32'd1,
    parameter bit          HALT_ON_SYSCALL = 1'b1
) (
    input  logic          clk,
    input  logic          rst_n,
    fetch_stage_if.master bus
);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        valid_q, valid_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] idpc_q, idpc_d;
    logic [31:0] idpc1_q, idpc1_d;
    logic        halted_q, halted_d;
    logic [31:0] pc_next;
    logic        is_syscall;

    assign pc_next    = pc_q + PC_STEP;
    assign is_syscall = (bus.im_read_i[31:26] == 6'h00) &&
                        (bus.im_read_i[5:0] == 6'h0C);

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        valid_d  = valid_q;
        instr_d  = instr_q;
        idpc_d   = idpc_q;
        idpc1_d  = idpc1_q;
        halted_d = halted_q;
        case (state_q)
            // One idle cycle after reset; stall/redirect are not looked at.
            BOOT: state_d = RUN;
            RUN: begin
                if (bus.redirect_i) begin
                    // Redirect wins over stall: the flushed slot carries a NOP.
                    pc_d    = bus.redirect_pc_i;
                    valid_d = 1'b0;
                    instr_d = 32'h0;
                end else if (!bus.stall_i) begin
                    instr_d = bus.im_read_i;
                    idpc_d  = pc_q;
                    idpc1_d = pc_next;
                    valid_d = 1'b1;
                    if (HALT_ON_SYSCALL && is_syscall) begin
                        // PC stays on the SYSCALL so im_pc_o points at it.
                        state_d  = HALT;
                        halted_d = 1'b1;
                    end else begin
                        pc_d = pc_next;
                    end
                end
            end
            HALT: begin
                // SYSCALL is handed downstream once, then the slot empties.
                if (!bus.stall_i) begin
                    valid_d = 1'b0;
                end
            end
            default: state_d = BOOT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= BOOT;
            pc_q     <= RESET_PC;
            valid_q  <= 1'b0;
            instr_q  <= 32'h0;
            idpc_q   <= 32'h0;
            idpc1_q  <= 32'h0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            valid_q  <= valid_d;
            instr_q  <= instr_d;
            idpc_q   <= idpc_d;
            idpc1_q  <= idpc1_d;
            halted_q <= halted_d;
        end
    end

    assign bus.im_pc_o       = pc_q;
    assign bus.id_valid_o    = valid_q;
    assign bus.id_instr_o    = instr_q;
    assign bus.id_pc_o       = idpc_q;
    assign bus.id_pc_plus1_o = idpc1_q;
    assign bus.halted_o      = halted_q;
    assign bus.state_dbg     = state_q;

endmodule
